demux32_1x16_reg: RTL and testbench

Registered 32-bit 1-to-16 write distributor. It is the write-side counterpart of the 16x1 read mux: one 32-bit input word goes to one of 16 holding registers, selected by a 4-bit select. Each channel has an EMPTY/FULL occupancy flag. Producer and consumers use a valid/ready and per-channel ack handshake, so a channel cannot be overwritten before it is consumed.

---
 rtl/demux32_1x16_reg.sv | 117 +++++++++++
 tb/tb_demux32_1x16_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/demux32_1x16_reg.sv
// Registered 1-to-16 write distributor with per-channel EMPTY/FULL occupancy,
// valid/ready producer handshake and per-channel consumer acks.
module demux32_1x16_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [SEL_WIDTH-1:0]  S,
  input  logic                  IN_VALID,
  input  logic                  BCAST,
  output logic                  IN_READY,
  output logic [DATA_WIDTH-1:0] Y0,
  output logic [DATA_WIDTH-1:0] Y1,
  output logic [DATA_WIDTH-1:0] Y2,
  output logic [DATA_WIDTH-1:0] Y3,
  output logic [DATA_WIDTH-1:0] Y4,
  output logic [DATA_WIDTH-1:0] Y5,
  output logic [DATA_WIDTH-1:0] Y6,
  output logic [DATA_WIDTH-1:0] Y7,
  output logic [DATA_WIDTH-1:0] Y8,
  output logic [DATA_WIDTH-1:0] Y9,
  output logic [DATA_WIDTH-1:0] Y10,
  output logic [DATA_WIDTH-1:0] Y11,
  output logic [DATA_WIDTH-1:0] Y12,
  output logic [DATA_WIDTH-1:0] Y13,
  output logic [DATA_WIDTH-1:0] Y14,
  output logic [DATA_WIDTH-1:0] Y15,
  output logic [(2**SEL_WIDTH)-1:0] OUT_FULL,
  input  logic [(2**SEL_WIDTH)-1:0] OUT_ACK,
  output logic [SEL_WIDTH:0]    WR_COUNT
);

  localparam int unsigned NCH   = 2 ** SEL_WIDTH;
  localparam int unsigned CNT_W = SEL_WIDTH + 1;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_e;

  chan_state_e           state_q [NCH];
  chan_state_e           state_d [NCH];
  logic [DATA_WIDTH-1:0] y_q     [NCH];
  logic [DATA_WIDTH-1:0] y_d     [NCH];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [NCH-1:0]        full_vec;
  logic                  accept;

  // Occupancy vector and producer ready, derived from registered state only.
  always_comb begin
    full_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      full_vec[i] = (state_q[i] == CH_FULL);
    end
    IN_READY = 1'b0;
    if (!RST) begin
      IN_READY = BCAST ? (full_vec == '0) : ~full_vec[S];
    end
  end

  // Per-channel next state: acks drain FULL channels, accepted writes fill them.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    count_d = '0;
    accept  = IN_VALID & IN_READY;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q[i] == CH_FULL) && OUT_ACK[i]) begin
        state_d[i] = CH_EMPTY;
      end
      if (accept && (BCAST || (S == SEL_WIDTH'(i)))) begin
        state_d[i] = CH_FULL;
        y_d[i]     = D;
      end
      count_d = count_d + CNT_W'(state_d[i] == CH_FULL);
    end
  end

  // State, data and count registers; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= CH_EMPTY;
        y_q[i]     <= '0;
      end
      count_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      count_q <= count_d;
    end
  end

  assign OUT_FULL = full_vec;
  assign WR_COUNT = count_q;

  assign Y0  = y_q[0];
  assign Y1  = y_q[1];
  assign Y2  = y_q[2];
  assign Y3  = y_q[3];
  assign Y4  = y_q[4];
  assign Y5  = y_q[5];
  assign Y6  = y_q[6];
  assign Y7  = y_q[7];
  assign Y8  = y_q[8];
  assign Y9  = y_q[9];
  assign Y10 = y_q[10];
  assign Y11 = y_q[11];
  assign Y12 = y_q[12];
  assign Y13 = y_q[13];
  assign Y14 = y_q[14];
  assign Y15 = y_q[15];

endmodule

// File: tb/tb_demux32_1x16_reg.sv
// Randomized and directed bench for demux32_1x16_reg against a behavioural model.
module tb_demux32_1x16_reg;

  logic        clk;
  logic        rst;
  logic [31:0] d;
  logic [3:0]  s;
  logic        in_valid;
  logic        bcast;
  logic        in_ready;
  wire  [15:0][31:0] y_bus;
  logic [15:0] out_full;
  logic [15:0] out_ack;
  logic [4:0]  wr_count;

  int unsigned n_vec;
  int unsigned n_err;
  bit          chk_en;

  // Behavioural model: stored words and occupancy bits.
  logic [31:0] m_y [16];
  logic [15:0] m_full;

  demux32_1x16_reg dut (
    .CLK(clk), .RST(rst), .D(d), .S(s), .IN_VALID(in_valid), .BCAST(bcast),
    .IN_READY(in_ready),
    .Y0(y_bus[0]),   .Y1(y_bus[1]),   .Y2(y_bus[2]),   .Y3(y_bus[3]),
    .Y4(y_bus[4]),   .Y5(y_bus[5]),   .Y6(y_bus[6]),   .Y7(y_bus[7]),
    .Y8(y_bus[8]),   .Y9(y_bus[9]),   .Y10(y_bus[10]), .Y11(y_bus[11]),
    .Y12(y_bus[12]), .Y13(y_bus[13]), .Y14(y_bus[14]), .Y15(y_bus[15]),
    .OUT_FULL(out_full), .OUT_ACK(out_ack), .WR_COUNT(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_ready();
    if (rst) return 1'b0;
    if (bcast) return (m_full == 16'h0000);
    return !m_full[s];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) chk($sformatf("Y%0d", i), y_bus[i], m_y[i]);
    chk("OUT_FULL", 32'(out_full), 32'(m_full));
    chk("WR_COUNT", 32'(wr_count), 32'($countones(m_full)));
    chk("IN_READY", 32'(in_ready), 32'(exp_ready()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_y[i] = 32'h0;
    m_full = 16'h0000;
  endtask

  // Apply the transfer rules to the model at a rising edge.
  task automatic model_step();
    logic [15:0] nf;
    if (rst) return;
    nf = m_full & ~out_ack;
    if (in_valid && exp_ready()) begin
      if (bcast) begin
        for (int i = 0; i < 16; i++) m_y[i] = d;
        nf = 16'hFFFF;
      end else begin
        m_y[s] = d;
        nf[s]  = 1'b1;
      end
    end
    m_full = nf;
  endtask

  // One cycle of stimulus: drive, take the edge, update the model, return to idle.
  task automatic cyc(input bit v, input bit b, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [15:0] ack);
    in_valid = v; bcast = b; s = sel; d = dat; out_ack = ack;
    @(posedge clk);
    model_step();
    #1;
    in_valid = 1'b0; bcast = 1'b0; out_ack = 16'h0000;
  endtask

  // Compare process: full output check against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) check_all();
  end

  initial begin
    logic [31:0] pat;
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    rst = 1'b1; in_valid = 1'b1; bcast = 1'b0; s = 4'd3;
    d = 32'hDEADBEEF; out_ack = 16'hFFFF;
    model_reset();
    #3;
    check_all();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0; out_ack = 16'h0000; s = 4'd0;
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b1;

    // Unicast
    cyc(1'b1, 1'b0, 4'd3, 32'hacdefb00, 16'h0);
    chk("uni_y3", y_bus[3], 32'hacdefb00);
    chk("uni_full", 32'(out_full), 32'h0008);
    chk("uni_cnt", 32'(wr_count), 32'd1);

    // Back-pressure, then ack frees the channel
    in_valid = 1'b1; s = 4'd3; d = 32'h12345678; #1;
    chk("bp_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 1'b0, 4'd3, 32'h12345678, 16'h0);
    chk("bp_hold_y3", y_bus[3], 32'hacdefb00);
    cyc(1'b1, 1'b0, 4'd3, 32'h12345678, 16'h0008);
    chk("bp_ack_full", 32'(out_full), 32'h0000);
    cyc(1'b1, 1'b0, 4'd3, 32'h12345678, 16'h0);
    chk("bp_y3", y_bus[3], 32'h12345678);
    chk("bp_cnt", 32'(wr_count), 32'd1);
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 16'h0008);

    // Sweep fill
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      pat = 32'h88888888;
      else if (i == 1) pat = 32'h99999999;
      else             pat = {{4{4'(i + 8)}}, 16'(16'h1010 + 16'(i - 2) * 16'h0101)};
      cyc(1'b1, 1'b0, 4'(i), pat, 16'h0);
    end
    chk("fill_full", 32'(out_full), 32'hFFFF);
    chk("fill_cnt", 32'(wr_count), 32'd16);
    chk("fill_y7", y_bus[7], 32'hffff1515);
    bcast = 1'b1; #1;
    chk("fill_ready_bc", 32'(in_ready), 32'd0);
    bcast = 1'b0; s = 4'd9; #1;
    chk("fill_ready_s9", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 16'hFFFF);
    chk("ackall_full", 32'(out_full), 32'h0000);
    chk("ackall_cnt", 32'(wr_count), 32'd0);
    chk("ackall_y0", y_bus[0], 32'h88888888);

    // Broadcast, then broadcast blocked by one FULL channel
    cyc(1'b1, 1'b1, 4'd0, 32'h55555555, 16'h0);
    chk("bc_y9", y_bus[9], 32'h55555555);
    chk("bc_full", 32'(out_full), 32'hFFFF);
    chk("bc_cnt", 32'(wr_count), 32'd16);
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 16'hFF7F);
    cyc(1'b1, 1'b1, 4'd0, 32'h66666666, 16'h0);
    chk("bc_blk_y0", y_bus[0], 32'h55555555);
    chk("bc_blk_full", 32'(out_full), 32'h0080);

    // Write and ack on different channels in one edge
    cyc(1'b1, 1'b0, 4'd5, 32'hCAFE0005, 16'h0080);
    cyc(1'b1, 1'b0, 4'd2, 32'hCAFE0002, 16'h0020);
    chk("conc_full", 32'(out_full), 32'h0004);
    chk("conc_cnt", 32'(wr_count), 32'd1);
    chk("conc_y2", y_bus[2], 32'hCAFE0002);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
          4'($urandom_range(0, 15)), $urandom(),
          16'($urandom() & $urandom() & $urandom()));
    end

    // Asynchronous reset between edges
    in_valid = 1'b1; s = 4'($urandom_range(0, 15)); d = $urandom();
    @(negedge clk); #2;
    rst = 1'b1; #1;
    model_reset();
    chk("arst_full", 32'(out_full), 32'h0000);
    chk("arst_cnt", 32'(wr_count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 1) != 0), ($urandom_range(0, 7) == 0),
          4'($urandom_range(0, 15)), $urandom(), 16'($urandom() & $urandom()));
    end

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
